// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared opcode, state and PC-select encodings for the multicycle sequencer
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    FORMAT_R = 2'd0,
    FORMAT_I = 2'd1,
    FORMAT_B = 2'd2,
    FORMAT_J = 2'd3
  } format_e;

  localparam logic [4:0] OP_ADD  = 5'h01;
  localparam logic [4:0] OP_AND  = 5'h02;
  localparam logic [4:0] OP_MOV  = 5'h03;
  localparam logic [4:0] OP_LD   = 5'h04;
  localparam logic [4:0] OP_ST   = 5'h05;
  localparam logic [4:0] OP_BR   = 5'h06;
  localparam logic [4:0] OP_JMP  = 5'h07;
  localparam logic [4:0] OP_JSR  = 5'h08;
  localparam logic [4:0] OP_JSRR = 5'h09;

  localparam logic [1:0] PC_SEL_INC  = 2'd0;
  localparam logic [1:0] PC_SEL_REL  = 2'd1;
  localparam logic [1:0] PC_SEL_BASE = 2'd2;

  function automatic logic op_legal(input logic [4:0] op);
    case (op)
      OP_ADD, OP_AND, OP_MOV, OP_LD, OP_ST,
      OP_BR, OP_JMP, OP_JSR, OP_JSRR: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - sequencer <-> datapath control and data-memory handshake bundle
interface multicycle_ctrl_if;
  logic [4:0] opcode;
  logic [2:0] br_mask;
  logic [2:0] cc;
  logic       mem_ready;
  logic       ir_ld;
  logic       pc_ld;
  logic [1:0] pc_sel;
  logic       reg_ld;
  logic       link_sel;
  logic       cc_ld;
  logic       mem_req;
  logic       mem_we;

  modport master (
    input  opcode, br_mask, cc, mem_ready,
    output ir_ld, pc_ld, pc_sel, reg_ld, link_sel, cc_ld, mem_req, mem_we
  );

  modport slave (
    output opcode, br_mask, cc, mem_ready,
    input  ir_ld, pc_ld, pc_sel, reg_ld, link_sel, cc_ld, mem_req, mem_we
  );
endinterface

// File: rtl/multicycle_ctrl_branch_eval.sv
// rtl/multicycle_ctrl_branch_eval.sv - BR taken evaluation from n/z/p mask and condition codes
module multicycle_ctrl_branch_eval (
  input  logic [2:0] br_mask,
  input  logic [2:0] cc,
  output logic       taken
);
  assign taken = |(br_mask & cc);
endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - FETCH/DECODE/EXEC/MEM/WB control sequencer with retire counter and trap
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                lock,
  multicycle_ctrl_if.master   bus,
  output logic                retire,
  output logic                trap,
  output logic [CNT_W-1:0]    instr_count,
  output logic [2:0]          state
);

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TCNT_MAX = TW'(MEM_TIMEOUT - 1);

  state_e          st_q, st_d;
  logic [4:0]      op_q;
  logic [TW-1:0]   tcnt_q;
  logic            trap_q;
  logic            br_taken;

  multicycle_ctrl_branch_eval u_branch_eval (
    .br_mask (bus.br_mask),
    .cc      (bus.cc),
    .taken   (br_taken)
  );

  // MEM ignores lock so an outstanding request completes (or times out) on its own.
  always_comb begin
    st_d         = st_q;
    bus.ir_ld    = 1'b0;
    bus.pc_ld    = 1'b0;
    bus.pc_sel   = PC_SEL_INC;
    bus.reg_ld   = 1'b0;
    bus.link_sel = 1'b0;
    bus.cc_ld    = 1'b0;
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    retire       = 1'b0;
    case (st_q)
      S_IDLE: begin
        if (lock) st_d = S_FETCH;
      end
      S_FETCH: begin
        if (lock) begin
          bus.ir_ld  = 1'b1;
          bus.pc_ld  = 1'b1;
          bus.pc_sel = PC_SEL_INC;
          st_d       = S_DECODE;
        end
      end
      S_DECODE: begin
        if (lock) st_d = op_legal(bus.opcode) ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        if (lock) begin
          case (op_q)
            OP_ADD, OP_AND, OP_MOV: st_d = S_WB;
            OP_LD, OP_ST:           st_d = S_MEM;
            OP_BR: begin
              bus.pc_ld  = br_taken;
              bus.pc_sel = br_taken ? PC_SEL_REL : PC_SEL_INC;
              retire     = 1'b1;
              st_d       = S_FETCH;
            end
            OP_JMP: begin
              bus.pc_ld  = 1'b1;
              bus.pc_sel = PC_SEL_BASE;
              retire     = 1'b1;
              st_d       = S_FETCH;
            end
            OP_JSR, OP_JSRR: begin
              bus.reg_ld   = 1'b1;
              bus.link_sel = 1'b1;
              bus.pc_ld    = 1'b1;
              bus.pc_sel   = (op_q == OP_JSR) ? PC_SEL_REL : PC_SEL_BASE;
              retire       = 1'b1;
              st_d         = S_FETCH;
            end
            default: st_d = S_TRAP;
          endcase
        end
      end
      S_MEM: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = (op_q == OP_ST);
        if (bus.mem_ready) begin
          if (op_q == OP_ST) begin
            retire = 1'b1;
            st_d   = S_FETCH;
          end else begin
            st_d = S_WB;
          end
        end else if (tcnt_q == TCNT_MAX) begin
          st_d = S_TRAP;
        end
      end
      S_WB: begin
        if (lock) begin
          bus.reg_ld = 1'b1;
          bus.cc_ld  = 1'b1;
          retire     = 1'b1;
          st_d       = S_FETCH;
        end
      end
      S_TRAP:  st_d = S_TRAP;
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q        <= S_IDLE;
      op_q        <= 5'd0;
      tcnt_q      <= '0;
      trap_q      <= 1'b0;
      instr_count <= '0;
    end else begin
      st_q <= st_d;
      if (st_q == S_DECODE && lock) op_q <= bus.opcode;
      if (st_q == S_EXEC && lock)
        tcnt_q <= '0;
      else if (st_q == S_MEM && !bus.mem_ready)
        tcnt_q <= tcnt_q + 1'b1;
      if (st_d == S_TRAP) trap_q <= 1'b1;
      if (retire) instr_count <= instr_count + 1'b1;
    end
  end

  assign trap  = trap_q;
  assign state = st_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - table-driven and scoreboard checks for the multicycle sequencer
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  typedef struct {
    logic [4:0] op;
    logic [2:0] mask;
    logic [2:0] ccv;
    int lows;
    int cyc;
    int xpc_ld;
    int xsel;
    int reg_ld;
    int cc_ld;
    int link;
    int mem_cyc;
    int we_cyc;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, lock, mem_ready;
  logic [4:0]  opcode;
  logic [2:0]  br_mask, cc;
  logic        retire, trap, retire4, trap4;
  logic [15:0] instr_count;
  logic [3:0]  cnt4;
  logic [2:0]  state, state4;
  logic [9:0]  all_str;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_count = 0;
  vec_t exp_q[$];
  vec_t tbl[14];

  multicycle_ctrl_if dp();
  multicycle_ctrl_if dp4();

  assign dp.opcode     = opcode;
  assign dp.br_mask    = br_mask;
  assign dp.cc         = cc;
  assign dp.mem_ready  = mem_ready;
  assign dp4.opcode    = opcode;
  assign dp4.br_mask   = br_mask;
  assign dp4.cc        = cc;
  assign dp4.mem_ready = mem_ready;
  assign all_str = {dp.ir_ld, dp.pc_ld, dp.pc_sel, dp.reg_ld, dp.link_sel,
                    dp.cc_ld, dp.mem_req, dp.mem_we, retire};

  multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .lock(lock), .bus(dp.master),
    .retire(retire), .trap(trap), .instr_count(instr_count), .state(state)
  );

  multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .lock(lock), .bus(dp4.master),
    .retire(retire4), .trap(trap4), .instr_count(cnt4), .state(state4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Called at a negedge; returns at a later negedge with state IDLE and reset released.
  task automatic do_reset();
    reset = 1'b1; lock = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    check("rst_state", state, 0);
    check("rst_strobes", all_str, 0);
    check("rst_trap", trap, 0);
    check("rst_count", instr_count, 0);
    reset = 1'b0;
    exp_count = 0;
  endtask

  // Called at the negedge of a FETCH cycle; returns at the negedge of the next FETCH.
  task automatic run_instr(input vec_t v);
    vec_t e;
    int ncyc, mcnt, xpc, xsel, rl, cl, lk, mc, wc, fetch_ok;
    bit done;
    opcode = v.op; br_mask = v.mask; cc = v.ccv;
    exp_q.push_back(v);
    ncyc = 0; mcnt = 0; xpc = 0; xsel = 0; rl = 0; cl = 0; lk = 0; mc = 0; wc = 0;
    fetch_ok = 0; done = 1'b0;
    while (!done && ncyc < 40) begin
      mem_ready = dp.mem_req ? (mcnt >= v.lows) : 1'b1;
      #1;
      ncyc++;
      if (ncyc == 1)
        fetch_ok = int'(state == 3'd1 && dp.ir_ld && dp.pc_ld && dp.pc_sel == 2'd0);
      else if (dp.pc_ld) begin
        xpc++;
        xsel = dp.pc_sel;
      end
      rl += dp.reg_ld;
      cl += dp.cc_ld;
      lk += dp.link_sel;
      wc += dp.mem_we;
      if (dp.mem_req) begin
        mc++;
        mcnt++;
      end
      if (retire) done = 1'b1;
      @(negedge clk);
    end
    e = exp_q.pop_front();
    check("retired", int'(done), 1);
    if (done) exp_count++;
    check("fetch_strobes", fetch_ok, 1);
    check("cycles", ncyc, e.cyc);
    check("exec_pc_ld", xpc, e.xpc_ld);
    check("exec_pc_sel", xsel, e.xsel);
    check("reg_ld", rl, e.reg_ld);
    check("cc_ld", cl, e.cc_ld);
    check("link_sel", lk, e.link);
    check("mem_cycles", mc, e.mem_cyc);
    check("mem_we", wc, e.we_cyc);
    check("instr_count", instr_count, exp_count);
  endtask

  initial begin
    int k, mcnt, n;
    logic [2:0] seq[5];
    tbl[0]  = '{OP_ADD,  3'b000, 3'b000, 0, 4, 0, 0, 1, 1, 0, 0, 0};
    tbl[1]  = '{OP_AND,  3'b000, 3'b000, 0, 4, 0, 0, 1, 1, 0, 0, 0};
    tbl[2]  = '{OP_MOV,  3'b000, 3'b000, 0, 4, 0, 0, 1, 1, 0, 0, 0};
    tbl[3]  = '{OP_BR,   3'b010, 3'b010, 0, 3, 1, 1, 0, 0, 0, 0, 0};
    tbl[4]  = '{OP_BR,   3'b010, 3'b100, 0, 3, 0, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{OP_BR,   3'b111, 3'b001, 0, 3, 1, 1, 0, 0, 0, 0, 0};
    tbl[6]  = '{OP_BR,   3'b000, 3'b111, 0, 3, 0, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{OP_JMP,  3'b000, 3'b000, 0, 3, 1, 2, 0, 0, 0, 0, 0};
    tbl[8]  = '{OP_JSR,  3'b000, 3'b000, 0, 3, 1, 1, 1, 0, 1, 0, 0};
    tbl[9]  = '{OP_JSRR, 3'b000, 3'b000, 0, 3, 1, 2, 1, 0, 1, 0, 0};
    tbl[10] = '{OP_LD,   3'b000, 3'b000, 3, 8, 0, 0, 1, 1, 0, 4, 0};
    tbl[11] = '{OP_LD,   3'b000, 3'b000, 0, 5, 0, 0, 1, 1, 0, 1, 0};
    tbl[12] = '{OP_ST,   3'b000, 3'b000, 0, 4, 0, 0, 0, 0, 0, 1, 1};
    tbl[13] = '{OP_ST,   3'b000, 3'b000, 2, 6, 0, 0, 0, 0, 0, 3, 3};
    seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5};
    opcode = 5'd0; br_mask = 3'd0; cc = 3'd0;
    do_reset();

    // ADD walk-through from IDLE
    opcode = OP_ADD;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = 1'b0;
      #1;
      check("alu_state", state, seq[i]);
      check("alu_retire", retire, (i == 4) ? 1 : 0);
      check("alu_reg_ld", dp.reg_ld, (i == 4) ? 1 : 0);
      check("alu_cc_ld", dp.cc_ld, (i == 4) ? 1 : 0);
    end
    @(negedge clk);
    exp_count = 1;
    check("alu_back_fetch", state, 1);
    check("alu_count", instr_count, 1);

    for (int i = 0; i < 14; i++) run_instr(tbl[i]);

    // ST with mem_ready never arriving
    opcode = OP_ST; mem_ready = 1'b0; mcnt = 0; k = 0;
    while (state != 3'd6 && k < 60) begin
      #1;
      if (dp.mem_req) mcnt++;
      @(negedge clk);
      k++;
    end
    check("timeout_mem_cycles", mcnt, 16);
    check("timeout_state", state, 6);
    check("timeout_trap", trap, 1);
    for (int i = 0; i < 3; i++) begin
      lock = i[0]; mem_ready = 1'b1;
      #1;
      check("trap_hold_state", state, 6);
      check("trap_hold_strobes", all_str, 0);
      @(negedge clk);
    end
    check("trap_sticky", trap, 1);
    do_reset();

    // lock drops in the 2nd MEM cycle of a ST
    @(negedge clk);
    opcode = OP_ST; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("ld_mem1_state", state, 4);
    @(negedge clk);
    lock = 1'b0;
    #1;
    check("lk_mem_req2", dp.mem_req, 1);
    check("lk_mem_we2", dp.mem_we, 1);
    @(negedge clk);
    #1;
    check("lk_mem_req3", dp.mem_req, 1);
    check("lk_retire3", retire, 0);
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check("lk_mem_req4", dp.mem_req, 1);
    check("lk_retire4", retire, 1);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("lk_frozen_state", state, 1);
      check("lk_frozen_ir_ld", dp.ir_ld, 0);
      n += retire;
    end
    check("lk_extra_retire", n, 0);
    check("lk_count", instr_count, 1);
    lock = 1'b1;
    #1;
    check("lk_resume_ir_ld", dp.ir_ld, 1);
    @(negedge clk);
    check("lk_resume_state", state, 2);

    // lock falls in FETCH, then illegal opcode
    do_reset();
    @(negedge clk);
    lock = 1'b0;
    #1;
    check("fetch_lock_ir_ld", dp.ir_ld, 0);
    check("fetch_lock_pc_ld", dp.pc_ld, 0);
    @(negedge clk);
    check("fetch_lock_hold", state, 1);
    lock = 1'b1; opcode = 5'h1F;
    @(negedge clk);
    check("ill_decode", state, 2);
    check("ill_trap_pre", trap, 0);
    @(negedge clk);
    check("ill_state", state, 6);
    check("ill_trap", trap, 1);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n += dp.pc_ld + dp.reg_ld + dp.mem_req;
      @(negedge clk);
    end
    check("ill_no_strobes", n, 0);

    // reset wins over mem_ready in MEM
    do_reset();
    @(negedge clk);
    opcode = OP_LD; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rw_mem_state", state, 4);
    reset = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    check("rw_state", state, 0);
    check("rw_strobes", all_str, 0);
    check("rw_count", instr_count, 0);
    reset = 1'b0;

    // CNT_W=4 wrap after 16 retires
    do_reset();
    opcode = OP_JMP; mem_ready = 1'b0; n = 0; k = 0;
    while (n < 16 && k < 100) begin
      #1;
      if (retire4) n++;
      @(negedge clk);
      k++;
    end
    check("wrap_retires", n, 16);
    check("wrap_cnt4", cnt4, 0);
    check("wrap_cnt16", instr_count, 16);
    check("wrap_state4", state4, 1);
    check("wrap_trap4", trap4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control sequencer for the integer datapath.
- Replaces the datapath's single-edge fetch/execute with an explicit FETCH/DECODE/EXEC/MEM/WB state machine.
- Drives the datapath's load enables, PC-source select and data-memory handshake, and counts retired instructions.
- Sits beside the datapath. It reads the opcode, branch mask and CC from it, and returns per-cycle control strobes.

Parameters:
MEM_TIMEOUT, 16, maximum MEM-state cycles without mem_ready before trapping.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
lock  in  1  run enable. When low, the FSM freezes (see Behaviour).
opcode  in  5  IR[31:27] from the datapath.
br_mask  in  3  IR[26:24], n/z/p mask for BR.
cc  in  3  datapath condition codes {n,z,p}.
mem_ready  in  1  data memory completes the current request.
ir_ld  out  1  load IR from instruction memory.
pc_ld  out  1  load PC.
pc_sel  out  2  PC source: 0 = PC+4, 1 = PC-relative target, 2 = base register.
reg_ld  out  1  write the register file.
link_sel  out  1  writeback source is the link (old PC+4), and the destination is R7.
cc_ld  out  1  update CC.
mem_req  out  1  data memory request.
mem_we  out  1  request is a store.
retire  out  1  one-cycle pulse when an instruction completes.
trap  out  1  sticky illegal-opcode or memory-timeout flag.
instr_count  out  CNT_W  retired-instruction counter.
state  out  3  current state, for debug.

Behaviour:
- Reset: state=IDLE, op_q=0, timeout counter=0, instr_count=0, trap=0. Every strobe output is 0. Reset overrides lock and all other inputs.
- Strobes are combinational from state and op_q. Every strobe is 0 in IDLE and TRAP, and whenever lock=0 outside MEM.
- State encoding is fixed: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- IDLE: go to FETCH when lock=1.
- FETCH:
  - ir_ld=1, pc_ld=1, pc_sel=0.
  - Next state is DECODE.
- DECODE:
  - Latch opcode into op_q.
  - Opcode not one of ADD/AND/MOV/LD/ST/BR/JMP/JSR/JSRR: trap=1, go to TRAP.
  - Otherwise go to EXEC.
- EXEC:
  - ADD/AND/MOV: go to WB.
  - LD/ST: clear the timeout counter, go to MEM.
  - BR: taken = |(br_mask & cc). If taken, pc_ld=1 and pc_sel=1. retire=1, go to FETCH.
  - JMP: pc_ld=1, pc_sel=2. retire=1, go to FETCH.
  - JSR: reg_ld=1, link_sel=1, pc_ld=1, pc_sel=1. retire=1, go to FETCH.
  - JSRR: same as JSR but pc_sel=2.
- MEM:
  - mem_req=1. mem_we=1 for ST only.
  - If mem_ready=1 at the rising edge: LD goes to WB; ST pulses retire and goes to FETCH.
  - Otherwise the counter increments. When the counter reaches MEM_TIMEOUT-1 without ready: trap=1, go to TRAP.
  - mem_ready is ignored in every state except MEM.
- WB:
  - reg_ld=1, cc_ld=1. retire=1, go to FETCH.
- TRAP: absorbing state; only reset exits. trap stays 1.
- lock=0:
  - State, op_q and instr_count hold.
  - Exception: in MEM the outstanding request stays asserted (mem_req, mem_we held) until mem_ready. The FSM then advances one state, and no further state advances while lock=0.
  - If that step is the ST retire, the retire pulse still fires.
- Latency (lock=1, mem_ready tied high):
  - ALU op: 4 cycles.
  - BR/JMP/JSR/JSRR: 3 cycles.
  - ST: 4 cycles.
  - LD: 5 cycles.
  - Each low mem_ready cycle adds 1.
- instr_count increments on every retire and wraps modulo 2^CNT_W without a flag.
- Simultaneous cases:
  - If reset and mem_ready are both high in MEM, reset wins and the access is abandoned.
  - If lock falls in the same cycle as FETCH, that FETCH's strobes are suppressed.

Decomposition:
- OP_* opcodes, FORMAT_* codes and the state encodings go in global_def.h, shared with the datapath.
- The PC-select encodings also go in global_def.h.
- One natural sub-module: branch_eval (combinational taken = |(br_mask & cc)), reused later by a pipelined datapath.

Test Plan:
- Reset, then lock=1 with an OP_ADD opcode held: state sequence IDLE,FETCH,DECODE,EXEC,WB,FETCH; reg_ld=cc_ld=1 only in WB; retire at cycle 5; instr_count=1.
- OP_BR with br_mask=3'b010 and cc=3'b010: pc_ld=1, pc_sel=1 in EXEC. Repeat with cc=3'b100: pc_ld=0 in EXEC; retire fires both times.
- OP_LD with mem_ready low for 3 cycles: MEM lasts 4 cycles with mem_req=1, mem_we=0; then WB; total 8 cycles.
- OP_ST with mem_ready never asserted and MEM_TIMEOUT=16: trap=1 after 16 MEM cycles; state=6 held until reset; reset clears trap.
- lock dropped on the 2nd MEM cycle of an ST, mem_ready raised 2 cycles later: mem_req stays asserted; retire pulses once; state FETCH frozen with ir_ld=0 until lock returns.
- Illegal opcode 5'h1F: DECODE leads to TRAP next cycle with trap=1; no pc_ld, reg_ld or mem_req after DECODE. Separately, with CNT_W=4, 16 retires wrap instr_count to 0.
